mem_arbiter: RTL and testbench

Shares the single data-memory port between instruction fetch (IFU, read-only) and the load/store path (LSU, read/write) that feeds the MEM/WB stage. LSU has fixed priority with a starvation guard for IFU. One transaction is outstanding at a time, with a timeout that prevents a dead slave from hanging the pipeline. Flush support discards an in-flight fetch response.

---
 rtl/mem_arbiter_pkg.sv | 27 ++
 rtl/mem_arbiter_reg.sv | 25 ++
 rtl/mem_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared bus definitions for the data-memory port: widths, arbiter states
// and the latched request payload seen by the downstream memory.
package mem_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int STRB_W = 8;

    // Arbiter ownership states; the encodings are shared with IFU and LSU.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFU_RD = 2'd1,
        LSU_RD = 2'd2,
        LSU_WR = 2'd3
    } state_e;

    // Everything the memory side needs for one transaction.
    typedef struct packed {
        logic [ADDR_W-1:0] r_addr;
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_data;
        logic [STRB_W-1:0] w_strb;
    } payload_t;

    localparam int PAYLOAD_W = $bits(payload_t);

endpackage

// File: rtl/mem_arbiter_reg.sv
// Generic load-enable register used to hold the granted request payload.
module mem_arbiter_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wen_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    // Capture the input only when enabled; clear on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else if (wen_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter for the single data-memory port shared by instruction fetch and the
// load/store unit. LSU has fixed priority, IFU is protected by a starvation
// counter, one transaction is in flight at a time and a busy-cycle timeout
// aborts transactions to an unresponsive slave. Flush cancels delivery of an
// IFU response without disturbing the bus handshake.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    // instruction fetch, read only
    input  logic              ifu_r_ready,
    input  logic [ADDR_W-1:0] ifu_r_addr,
    output logic              ifu_r_valid,
    output logic [DATA_W-1:0] ifu_r_data,
    // load/store read
    input  logic              lsu_r_ready,
    input  logic [ADDR_W-1:0] lsu_r_addr,
    output logic              lsu_r_valid,
    output logic [DATA_W-1:0] lsu_r_data,
    // load/store write
    input  logic              lsu_w_valid,
    input  logic [ADDR_W-1:0] lsu_w_addr,
    input  logic [DATA_W-1:0] lsu_w_data,
    input  logic [STRB_W-1:0] lsu_w_strb,
    output logic              lsu_w_ready,
    // downstream memory
    output logic              mem_r_ready,
    output logic [ADDR_W-1:0] mem_r_addr,
    input  logic              mem_r_valid,
    input  logic [DATA_W-1:0] mem_r_data,
    output logic              mem_w_valid,
    output logic [ADDR_W-1:0] mem_w_addr,
    output logic [DATA_W-1:0] mem_w_data,
    output logic [STRB_W-1:0] mem_w_strb,
    input  logic              mem_w_ready,
    output logic              bus_timeout
);

    localparam int SC_W = $clog2(STARVE_MAX + 1);
    localparam int TC_W = $clog2(TIMEOUT + 1);

    localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);
    // tmo_q is 0 on the first busy cycle, so TIMEOUT-1 marks the last one.
    localparam logic [TC_W-1:0] TMO_LAST   = TC_W'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [SC_W-1:0] starve_q, starve_d;
    logic [TC_W-1:0] tmo_q, tmo_d;
    logic            drop_ifu_q, drop_ifu_d;
    logic            mem_r_ready_q, mem_r_ready_d;
    logic            mem_w_valid_q, mem_w_valid_d;

    logic            grant;
    payload_t        payload_d, payload_q;

    logic            rsp_rd, rsp_wr, tmo_hit, done;
    logic            ifu_fire, lsu_rd_fire, lsu_wr_fire;
    logic            starve_hit;

    assign starve_hit = ifu_r_ready && (starve_q == STARVE_LIM);

    // Work out whether the current transaction ends this cycle and why.
    always_comb begin
        rsp_rd  = mem_r_valid && ((state_q == IFU_RD) || (state_q == LSU_RD));
        rsp_wr  = mem_w_ready && (state_q == LSU_WR);
        // A real response in the final busy cycle beats the abort.
        tmo_hit = (state_q != IDLE) && !(rsp_rd || rsp_wr) && (tmo_q == TMO_LAST);
        done    = rsp_rd || rsp_wr || tmo_hit;
    end

    // Grant selection in IDLE, completion handling while busy, counters and flags.
    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        tmo_d      = '0;
        drop_ifu_d = drop_ifu_q;
        grant      = 1'b0;
        payload_d  = '0;

        case (state_q)
            IDLE: begin
                // A flush while nothing is fetching kills the next fetch.
                if (flush) begin
                    drop_ifu_d = 1'b1;
                end
                if (!ifu_r_ready) begin
                    starve_d = '0;
                end

                if (starve_hit) begin
                    state_d          = IFU_RD;
                    grant            = 1'b1;
                    payload_d.r_addr = ifu_r_addr;
                    starve_d         = '0;
                end else if (lsu_w_valid) begin
                    state_d          = LSU_WR;
                    grant            = 1'b1;
                    payload_d.w_addr = lsu_w_addr;
                    payload_d.w_data = lsu_w_data;
                    payload_d.w_strb = lsu_w_strb;
                end else if (lsu_r_ready) begin
                    state_d          = LSU_RD;
                    grant            = 1'b1;
                    payload_d.r_addr = lsu_r_addr;
                end else if (ifu_r_ready) begin
                    state_d          = IFU_RD;
                    grant            = 1'b1;
                    payload_d.r_addr = ifu_r_addr;
                    starve_d         = '0;
                end

                // An LSU win while IFU waits counts toward the starvation limit.
                if (grant && (state_d != IFU_RD) && ifu_r_ready && (starve_q != STARVE_LIM)) begin
                    starve_d = starve_q + 1'b1;
                end
            end

            default: begin
                if (done) begin
                    state_d = IDLE;
                    // The pending drop was consumed by this fetch.
                    if (state_q == IFU_RD) begin
                        drop_ifu_d = 1'b0;
                    end
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    if ((state_q == IFU_RD) && flush) begin
                        drop_ifu_d = 1'b1;
                    end
                end
            end
        endcase

        // Memory request lines are registered copies of the next ownership.
        mem_r_ready_d = (state_d == IFU_RD) || (state_d == LSU_RD);
        mem_w_valid_d = (state_d == LSU_WR);
    end

    // Arbiter state, counters and registered memory request strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            starve_q      <= '0;
            tmo_q         <= '0;
            drop_ifu_q    <= 1'b0;
            mem_r_ready_q <= 1'b0;
            mem_w_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            starve_q      <= starve_d;
            tmo_q         <= tmo_d;
            drop_ifu_q    <= drop_ifu_d;
            mem_r_ready_q <= mem_r_ready_d;
            mem_w_valid_q <= mem_w_valid_d;
        end
    end

    // Request payload is captured once, at grant, and held for the transaction.
    mem_arbiter_reg #(
        .W (PAYLOAD_W)
    ) u_payload (
        .clk   (clk),
        .rst   (rst),
        .wen_i (grant),
        .d_i   (payload_d),
        .q_o   (payload_q)
    );

    // Route the completion to its owner; flush suppresses a fetch on the same cycle.
    always_comb begin
        ifu_fire    = (state_q == IFU_RD) && done && !drop_ifu_q && !flush;
        lsu_rd_fire = (state_q == LSU_RD) && done;
        lsu_wr_fire = (state_q == LSU_WR) && done;
    end

    // Aborted reads return zero data; data is zero whenever no pulse is given.
    assign ifu_r_valid = ifu_fire;
    assign ifu_r_data  = (ifu_fire && rsp_rd) ? mem_r_data : '0;
    assign lsu_r_valid = lsu_rd_fire;
    assign lsu_r_data  = (lsu_rd_fire && rsp_rd) ? mem_r_data : '0;
    assign lsu_w_ready = lsu_wr_fire;
    assign bus_timeout = tmo_hit;

    assign mem_r_ready = mem_r_ready_q;
    assign mem_r_addr  = payload_q.r_addr;
    assign mem_w_valid = mem_w_valid_q;
    assign mem_w_addr  = payload_q.w_addr;
    assign mem_w_data  = payload_q.w_data;
    assign mem_w_strb  = payload_q.w_strb;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then
// random traffic against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int STARVE = 4;
    localparam int TMO    = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        ifu_r_ready;
    logic [31:0] ifu_r_addr;
    logic        ifu_r_valid;
    logic [63:0] ifu_r_data;
    logic        lsu_r_ready;
    logic [31:0] lsu_r_addr;
    logic        lsu_r_valid;
    logic [63:0] lsu_r_data;
    logic        lsu_w_valid;
    logic [31:0] lsu_w_addr;
    logic [63:0] lsu_w_data;
    logic [7:0]  lsu_w_strb;
    logic        lsu_w_ready;
    logic        mem_r_ready;
    logic [31:0] mem_r_addr;
    logic        mem_r_valid = 1'b0;
    logic [63:0] mem_r_data  = 64'h0;
    logic        mem_w_valid;
    logic [31:0] mem_w_addr;
    logic [63:0] mem_w_data;
    logic [7:0]  mem_w_strb;
    logic        mem_w_ready = 1'b0;
    logic        bus_timeout;

    mem_arbiter #(.STARVE_MAX(STARVE), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ifu_r_ready(ifu_r_ready), .ifu_r_addr(ifu_r_addr),
        .ifu_r_valid(ifu_r_valid), .ifu_r_data(ifu_r_data),
        .lsu_r_ready(lsu_r_ready), .lsu_r_addr(lsu_r_addr),
        .lsu_r_valid(lsu_r_valid), .lsu_r_data(lsu_r_data),
        .lsu_w_valid(lsu_w_valid), .lsu_w_addr(lsu_w_addr),
        .lsu_w_data(lsu_w_data), .lsu_w_strb(lsu_w_strb), .lsu_w_ready(lsu_w_ready),
        .mem_r_ready(mem_r_ready), .mem_r_addr(mem_r_addr),
        .mem_r_valid(mem_r_valid), .mem_r_data(mem_r_data),
        .mem_w_valid(mem_w_valid), .mem_w_addr(mem_w_addr),
        .mem_w_data(mem_w_data), .mem_w_strb(mem_w_strb), .mem_w_ready(mem_w_ready),
        .bus_timeout(bus_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- slave memory ----------------
    int sl_lat    = 1;     // fixed latency, or -1 for random 0..10
    bit sl_fix    = 1'b0;  // answer reads with the fixed pattern
    bit sl_silent = 1'b0;  // never answer
    bit sl_spur   = 1'b0;  // inject stray responses of the wrong kind
    bit sl_act    = 1'b0;
    int sl_cnt    = 0;

    always @(posedge clk) begin
        #1;
        mem_r_valid = 1'b0;
        mem_w_ready = 1'b0;
        mem_r_data  = 64'h0;
        if (rst || !(mem_r_ready || mem_w_valid)) begin
            sl_act = 1'b0;
        end else begin
            if (!sl_act) begin
                sl_act = 1'b1;
                sl_cnt = (sl_lat >= 0) ? sl_lat : $urandom_range(0, 10);
            end
            if (!sl_silent && sl_cnt == 0) begin
                if (mem_r_ready) begin
                    mem_r_valid = 1'b1;
                    mem_r_data  = sl_fix ? 64'h1122334455667788 : {$urandom, $urandom};
                end else begin
                    mem_w_ready = 1'b1;
                end
            end else if (sl_cnt > 0) begin
                sl_cnt--;
            end
        end
        if (sl_spur) begin
            if (!mem_r_ready && $urandom_range(0, 7) == 0) begin
                mem_r_valid = 1'b1;
                mem_r_data  = {$urandom, $urandom};
            end
            if (!mem_w_valid && $urandom_range(0, 7) == 0) mem_w_ready = 1'b1;
        end
    end

    // ---------------- reference model + compare ----------------
    bit          m_busy   = 1'b0;
    byte         m_who    = 8'd0;   // "I" fetch, "R" lsu read, "W" lsu write
    int          m_age    = 0;      // busy cycle index, 1 on first busy cycle
    int          m_starve = 0;
    bit          m_drop   = 1'b0;
    logic [31:0] m_raddr  = 32'h0;
    logic [31:0] m_waddr  = 32'h0;
    logic [63:0] m_wdata  = 64'h0;
    logic [7:0]  m_wstrb  = 8'h0;

    always @(negedge clk) begin : model_blk
        bit          resp, tmo, fin, e_iv, e_rv, e_wv;
        logic [63:0] e_id, e_rd;
        if (rst) begin
            chk("rst_ifu_v", ifu_r_valid, 0);
            chk("rst_ifu_d", ifu_r_data, 0);
            chk("rst_lsu_rv", lsu_r_valid, 0);
            chk("rst_lsu_rd", lsu_r_data, 0);
            chk("rst_lsu_wr", lsu_w_ready, 0);
            chk("rst_mem_rr", mem_r_ready, 0);
            chk("rst_mem_wv", mem_w_valid, 0);
            chk("rst_mem_ra", mem_r_addr, 0);
            chk("rst_mem_wa", mem_w_addr, 0);
            chk("rst_mem_wd", mem_w_data, 0);
            chk("rst_mem_ws", mem_w_strb, 0);
            chk("rst_tmo", bus_timeout, 0);
            m_busy = 0; m_who = 8'd0; m_age = 0; m_starve = 0; m_drop = 0;
        end else begin
            resp = m_busy && ((m_who != "W" && mem_r_valid) || (m_who == "W" && mem_w_ready));
            tmo  = m_busy && !resp && (m_age == TMO);
            fin  = resp || tmo;
            e_iv = fin && m_who == "I" && !m_drop && !flush;
            e_rv = fin && m_who == "R";
            e_wv = fin && m_who == "W";
            e_id = (e_iv && resp) ? mem_r_data : 64'h0;
            e_rd = (e_rv && resp) ? mem_r_data : 64'h0;
            chk("ifu_r_valid", ifu_r_valid, e_iv);
            chk("ifu_r_data", ifu_r_data, e_id);
            chk("lsu_r_valid", lsu_r_valid, e_rv);
            chk("lsu_r_data", lsu_r_data, e_rd);
            chk("lsu_w_ready", lsu_w_ready, e_wv);
            chk("bus_timeout", bus_timeout, tmo);
            chk("mem_r_ready", mem_r_ready, m_busy && m_who != "W");
            chk("mem_w_valid", mem_w_valid, m_busy && m_who == "W");
            if (m_busy && m_who != "W") chk("mem_r_addr", mem_r_addr, m_raddr);
            if (m_busy && m_who == "W") begin
                chk("mem_w_addr", mem_w_addr, m_waddr);
                chk("mem_w_data", mem_w_data, m_wdata);
                chk("mem_w_strb", mem_w_strb, m_wstrb);
            end

            if (!m_busy) begin
                if (flush) m_drop = 1;
                if (ifu_r_ready && m_starve == STARVE) m_who = "I";
                else if (lsu_w_valid)                 m_who = "W";
                else if (lsu_r_ready)                 m_who = "R";
                else if (ifu_r_ready)                 m_who = "I";
                else                                  m_who = 8'd0;
                if (!ifu_r_ready || m_who == "I") m_starve = 0;
                else if (m_who != 8'd0 && m_starve < STARVE) m_starve++;
                if (m_who != 8'd0) begin
                    m_busy = 1;
                    m_age  = 1;
                    if (m_who == "I") m_raddr = ifu_r_addr;
                    if (m_who == "R") m_raddr = lsu_r_addr;
                    if (m_who == "W") begin
                        m_waddr = lsu_w_addr; m_wdata = lsu_w_data; m_wstrb = lsu_w_strb;
                    end
                end
            end else if (fin) begin
                if (m_who == "I") m_drop = 0;
                m_busy = 0;
                m_who  = 8'd0;
            end else begin
                m_age++;
                if (m_who == "I" && flush) m_drop = 1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    bit got_i = 0, got_r = 0, got_w = 0;

    initial begin
        rst = 1; flush = 0;
        ifu_r_ready = 0; ifu_r_addr = 0;
        lsu_r_ready = 0; lsu_r_addr = 0;
        lsu_w_valid = 0; lsu_w_addr = 0; lsu_w_data = 0; lsu_w_strb = 0;
        repeat (3) cyc();
        rst = 0;
        cyc();

        // lone IFU read, slave answers on second busy cycle
        sl_lat = 1; sl_fix = 1;
        ifu_r_ready = 1; ifu_r_addr = 32'h8000_0000;
        cyc(); #2;
        chk("t1_req", mem_r_ready, 1);
        chk("t1_addr", mem_r_addr, 32'h8000_0000);
        chk("t1_early", ifu_r_valid, 0);
        cyc(); #2;
        chk("t1_addr2", mem_r_addr, 32'h8000_0000);
        chk("t1_valid", ifu_r_valid, 1);
        chk("t1_data", ifu_r_data, 64'h1122334455667788);
        cyc(); ifu_r_ready = 0; #2;
        chk("t1_idle", mem_r_ready, 0);
        sl_fix = 0;

        // LSU write beats IFU read; IFU follows after one idle cycle
        cyc();
        sl_lat = 0;
        lsu_w_valid = 1; lsu_w_addr = 32'h40; lsu_w_data = 64'hdead_beef_0000_0001; lsu_w_strb = 8'h0f;
        ifu_r_ready = 1; ifu_r_addr = 32'h100;
        cyc(); #2;
        chk("t2_wv", mem_w_valid, 1);
        chk("t2_wa", mem_w_addr, 32'h40);
        chk("t2_wdone", lsu_w_ready, 1);
        chk("t2_norr", mem_r_ready, 0);
        cyc(); lsu_w_valid = 0; #2;
        chk("t2_gap_w", mem_w_valid, 0);
        chk("t2_gap_r", mem_r_ready, 0);
        cyc(); #2;
        chk("t2_ifu_addr", mem_r_addr, 32'h100);
        chk("t2_ifu_v", ifu_r_valid, 1);
        cyc(); ifu_r_ready = 0;

        // starvation: LSU reads back to back while IFU waits
        cyc();
        lsu_r_ready = 1; lsu_r_addr = 32'h1000;
        ifu_r_ready = 1; ifu_r_addr = 32'h2000;
        for (int c = 1; c <= 11; c++) begin
            cyc();
            if (c == 10) ifu_r_addr = 32'h2008;
            #2;
            chk("t3_lsu_v", lsu_r_valid, (c % 2 == 1 && c != 9) ? 1 : 0);
            chk("t3_ifu_v", ifu_r_valid, (c == 9) ? 1 : 0);
            if (c == 9)  chk("t3_ifu_addr", mem_r_addr, 32'h2000);
            if (c == 11) chk("t3_lsu_after", mem_r_addr, 32'h1000);
        end
        cyc(); lsu_r_ready = 0; ifu_r_ready = 0;

        // flush during fetch: bus completes, pulse dropped, refetch delivered
        cyc();
        sl_lat = 2;
        ifu_r_ready = 1; ifu_r_addr = 32'h3000;
        for (int c = 1; c <= 8; c++) begin
            cyc();
            if (c == 1) flush = 1;
            if (c == 2) flush = 0;
            if (c == 8) ifu_r_ready = 0;
            #2;
            chk("t4_ifu_v", ifu_r_valid, (c == 7) ? 1 : 0);
            chk("t4_req", mem_r_ready, ((c >= 1 && c <= 3) || (c >= 5 && c <= 7)) ? 1 : 0);
        end

        // silent slave: abort on busy cycle TMO
        cyc();
        sl_silent = 1;
        lsu_r_ready = 1; lsu_r_addr = 32'h5000;
        for (int c = 1; c <= 9; c++) begin
            cyc();
            if (c == 9) lsu_r_ready = 0;
            #2;
            chk("t5_tmo", bus_timeout, (c == TMO) ? 1 : 0);
            chk("t5_lsu_v", lsu_r_valid, (c == TMO) ? 1 : 0);
            chk("t5_req", mem_r_ready, (c <= TMO) ? 1 : 0);
            if (c == TMO) chk("t5_data", lsu_r_data, 64'h0);
        end

        // asynchronous reset in the middle of a write
        cyc();
        lsu_w_valid = 1; lsu_w_addr = 32'h6000; lsu_w_data = 64'h55; lsu_w_strb = 8'hff;
        cyc();
        cyc(); #1;
        chk("t6_pre", mem_w_valid, 1);
        rst = 1; #1;
        chk("t6_wv", mem_w_valid, 0);
        chk("t6_wdone", lsu_w_ready, 0);
        chk("t6_wa", mem_w_addr, 0);
        lsu_w_valid = 0;
        cyc(); rst = 0; sl_silent = 0;
        cyc(); #2;
        chk("t6_idle_w", mem_w_valid, 0);
        chk("t6_idle_r", mem_r_ready, 0);

        // random traffic against the model
        sl_lat = -1; sl_spur = 1;
        for (int c = 0; c < 3000; c++) begin
            cyc();
            if (got_i) ifu_r_ready = 0;
            else if (!ifu_r_ready && $urandom_range(0, 2) == 0) begin
                ifu_r_ready = 1; ifu_r_addr = $urandom;
            end
            if (got_r) lsu_r_ready = 0;
            else if (!lsu_r_ready && $urandom_range(0, 3) == 0) begin
                lsu_r_ready = 1; lsu_r_addr = $urandom;
            end
            if (got_w) lsu_w_valid = 0;
            else if (!lsu_w_valid && $urandom_range(0, 4) == 0) begin
                lsu_w_valid = 1; lsu_w_addr = $urandom;
                lsu_w_data = {$urandom, $urandom}; lsu_w_strb = 8'($urandom);
            end
            flush = ($urandom_range(0, 11) == 0);
            #3;
            got_i = ifu_r_valid; got_r = lsu_r_valid; got_w = lsu_w_ready;
        end
        flush = 0; ifu_r_ready = 0; lsu_r_ready = 0; lsu_w_valid = 0;
        repeat (3) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
